pipelined_mips_mem_responder: RTL and testbench
===============================================

# pipelined_mips_mem_responder

Memory-side counterpart of `PipelinedMIPSCPU`. It answers the core's instruction fetch (`PCF` → `IM_RD`) and data-memory port (`ALUOutM`/`WriteDataM`/`MemWriteM` → `DM_RD`). It also owns a boot loader that streams a program into instruction memory while holding the core in reset. It sits beside the core at SoC top level and replaces the hand-driven instruction/data words used in bench stimulus.

## Interface
- `IM_DEPTH`, 64: instruction memory size in 32-bit words; power of two, ≥ 2.
- `DM_DEPTH`, 64: data memory size in 32-bit words; power of two, ≥ 2.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `LoadValid`  in  1  loader word valid.
- `LoadData`  in  32  instruction word to load.
- `LoadLast`  in  1  marks the final word of the program; qualified by `LoadValid`.
- `LoadReady`  out  1  loader can accept a word.
- `CPU_RST`  out  1  reset to the core; high until loading finishes.
- `PCF`  in  32  fetch byte address from the core.
- `IM_RD`  out  32  fetched instruction.
- `MemWriteM`  in  1  data write enable from the core.
- `ALUOutM`  in  32  data byte address.
- `WriteDataM`  in  32  data write value.
- `DM_RD`  out  32  data read value.
- `LoadCount`  out  $clog2(IM_DEPTH)+1  number of words loaded.
- `Fault`  out  1  sticky flag for an illegal data write.
- `RunCycles`  out  32  cycles spent in RUN.

## Operation
- The FSM has two states, LOAD and RUN. Reset enters LOAD.
- LOAD state:
  - `LoadReady`=1 and `CPU_RST`=1.
  - A word is accepted when `LoadValid`&&`LoadReady`. It is written to `imem[LoadCount]` and `LoadCount` increments.
  - The FSM moves to RUN when the accepted word has `LoadLast`=1, or when it is word index `IM_DEPTH`-1 (auto-terminate).
  - `LoadValid`=0 stalls indefinitely with no state change.
- RUN state:
  - `LoadReady`=0 and `CPU_RST`=0. `LoadValid` is ignored.
  - `RunCycles` increments every cycle and saturates at 32'hFFFF_FFFF.
- Fetch (combinational, both states):
  - Word index = `PCF[31:2]`.
  - `IM_RD` = imem[index] when index < `LoadCount`; otherwise 0 (NOP). This covers out-of-range and unloaded addresses.
  - `PCF[1:0]` is ignored.
- Data read (combinational):
  - Word index = `ALUOutM[31:2]`.
  - `DM_RD` = dmem[index] if index < `DM_DEPTH` and `ALUOutM[1:0]`==0; otherwise 0.
- Data write:
  - Occurs at the rising edge only in RUN, only when `MemWriteM`=1, and only for an aligned, in-range address.
  - An illegal write (misaligned or out of range) is suppressed and sets `Fault`.
  - `MemWriteM` in LOAD is ignored and raises no fault.
- `Fault` is cleared only by `RST`.
- Memory contents are not cleared by reset:
  - Dmem contents are retained across `RST`.
  - Imem contents are invisible until reloaded, because `LoadCount` resets to 0.

## Timing
- Reset values: state=LOAD, `LoadReady`=1, `CPU_RST`=1, `LoadCount`=0, `Fault`=0, `RunCycles`=0, `IM_RD`=0.
- Loader: one word per cycle at full throughput.
- LOAD→RUN:
  - The transition edge is the edge that accepts the last word.
  - `CPU_RST` falls, and `LoadReady` falls, in the cycle after that edge. They are driven from registered state.
  - `RunCycles` first reads 1 one cycle after entering RUN.
- Fetch and data read have zero latency, i.e. same cycle as the address. This matches the core's single-cycle IF and MEM stages.
- Read-during-write to the same dmem word: `DM_RD` shows the old value that cycle and the new value the following cycle.
- `RST` asserted mid-LOAD or mid-RUN takes effect immediately (asynchronously) and returns to LOAD. A partial load is discarded by clearing `LoadCount`.
- `LoadLast` on the final depth word: same result as either terminating condition alone.

## Test plan
- Reset, then stream 3 words `0x20080005`, `0x20090003`, `0x01095020` with `LoadLast` on the third:
  - `LoadCount`=3.
  - `CPU_RST` drops the cycle after the third accept.
  - `PCF`=8 → `IM_RD`=`0x01095020`.
  - `PCF`=12 → `IM_RD`=0.
- Stream `IM_DEPTH`=64 words without `LoadLast`: RUN is entered after word 64, `LoadReady`=0, and a 65th `LoadValid` is ignored.
- In RUN, write `ALUOutM`=0x10, `WriteDataM`=0xDEADBEEF:
  - The same cycle shows the old `DM_RD`.
  - The next cycle shows `DM_RD`=0xDEADBEEF.
  - `Fault`=0.
- Write to `ALUOutM`=0x12 and to 0x100 (both with `DM_DEPTH`=64):
  - Both writes are suppressed.
  - `Fault`=1 and stays 1.
  - `DM_RD` reads 0 for both addresses.
- Pulse `RST` mid-load after 2 of 5 words:
  - `LoadCount`=0, `LoadReady`=1, `CPU_RST`=1.
  - A fresh 5-word load completes normally.
  - Dmem word 0x10 still reads 0xDEADBEEF, written before the reset.
- Hold `LoadValid` low for 20 cycles in LOAD: no state change, and `RunCycles` stays 0.

Source files
------------

// File: rtl/pipelined_mips_mem_responder.sv
// rtl/pipelined_mips_mem_responder.sv - instruction/data memory responder with boot loader for a pipelined MIPS core
//
// Purpose:
//   Serves the core's instruction fetch and data-memory port. After reset it
//   streams a program into instruction memory through the loader port and
//   holds the core in reset. It then releases the core and serves zero-latency
//   reads and edge-triggered data writes.
//
// Ports:
//   CLK, RST               clock; asynchronous active-high reset
//   LoadValid/LoadData/    loader stream; LoadLast marks the final word
//   LoadLast/LoadReady
//   CPU_RST                reset to the core, high while loading
//   PCF -> IM_RD           combinational instruction fetch
//   MemWriteM/ALUOutM/     data port: write at the clock edge, combinational read
//   WriteDataM -> DM_RD
//   LoadCount              number of instruction words loaded
//   Fault                  sticky flag for an illegal data write in RUN
//   RunCycles              saturating count of cycles spent in RUN

module pipelined_mips_mem_responder #(
  parameter int IM_DEPTH = 64,
  parameter int DM_DEPTH = 64
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        LoadValid,
  input  logic [31:0]                 LoadData,
  input  logic                        LoadLast,
  output logic                        LoadReady,
  output logic                        CPU_RST,
  input  logic [31:0]                 PCF,
  output logic [31:0]                 IM_RD,
  input  logic                        MemWriteM,
  input  logic [31:0]                 ALUOutM,
  input  logic [31:0]                 WriteDataM,
  output logic [31:0]                 DM_RD,
  output logic [$clog2(IM_DEPTH):0]   LoadCount,
  output logic                        Fault,
  output logic [31:0]                 RunCycles
);

  localparam int IAW = $clog2(IM_DEPTH);
  localparam int DAW = $clog2(DM_DEPTH);
  localparam int LCW = IAW + 1;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [LCW-1:0]   load_count_q, load_count_d;
  logic             fault_q, fault_d;
  logic [31:0]      run_cycles_q, run_cycles_d;

  // Memories carry no reset: dmem survives RST, and imem is hidden behind
  // LoadCount until it is reloaded.
  logic [31:0]      imem_q [IM_DEPTH];
  logic [31:0]      dmem_q [DM_DEPTH];

  logic             load_accept;
  logic             load_final;
  logic             dm_legal;
  logic             dm_write;
  logic             im_hit;

  // Byte-lane bits of the fetch address carry no information.
  logic             unused_pcf;
  assign unused_pcf = ^PCF[1:0];

  assign load_accept = LoadValid && (state_q == S_LOAD);
  // Auto-terminate once the last imem slot is filled, LoadLast or not.
  assign load_final  = LoadLast || (load_count_q == LCW'(IM_DEPTH - 1));

  assign dm_legal = (ALUOutM[1:0] == 2'b00) && (ALUOutM[31:2] < 30'(DM_DEPTH));
  assign dm_write = (state_q == S_RUN) && MemWriteM && dm_legal;

  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    fault_d      = fault_q;
    run_cycles_d = run_cycles_q;

    case (state_q)
      S_LOAD: begin
        if (load_accept) begin
          load_count_d = load_count_q + LCW'(1);
          if (load_final) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (run_cycles_q != 32'hFFFF_FFFF) begin
          run_cycles_d = run_cycles_q + 32'd1;
        end
        if (MemWriteM && !dm_legal) begin
          fault_d = 1'b1;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_LOAD;
      load_count_q <= '0;
      fault_q      <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      load_count_q <= load_count_d;
      fault_q      <= fault_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  // While loading, LoadCount stays below IM_DEPTH, so its low bits index imem.
  always_ff @(posedge CLK) begin
    if (load_accept) begin
      imem_q[load_count_q[IAW-1:0]] <= LoadData;
    end
  end

  always_ff @(posedge CLK) begin
    if (dm_write) begin
      dmem_q[ALUOutM[DAW+1:2]] <= WriteDataM;
    end
  end

  // Only loaded words are visible; everything else fetches as a NOP.
  assign im_hit = ({2'b00, PCF[31:2]} < 32'(load_count_q));
  assign IM_RD  = im_hit ? imem_q[PCF[IAW+1:2]] : 32'h0000_0000;
  assign DM_RD  = dm_legal ? dmem_q[ALUOutM[DAW+1:2]] : 32'h0000_0000;

  assign LoadReady = (state_q == S_LOAD);
  assign CPU_RST   = (state_q == S_LOAD);
  assign LoadCount = load_count_q;
  assign Fault     = fault_q;
  assign RunCycles = run_cycles_q;

endmodule

// File: tb/tb_pipelined_mips_mem_responder.sv
// tb/tb_pipelined_mips_mem_responder.sv - directed self-checking bench for pipelined_mips_mem_responder

module tb_pipelined_mips_mem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        LoadValid;
  logic [31:0] LoadData;
  logic        LoadLast;
  logic        LoadReady;
  logic        CPU_RST;
  logic [31:0] PCF;
  logic [31:0] IM_RD;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] DM_RD;
  logic [6:0]  LoadCount;
  logic        Fault;
  logic [31:0] RunCycles;

  int checks = 0;
  int errors = 0;

  pipelined_mips_mem_responder #(.IM_DEPTH(64), .DM_DEPTH(64)) dut (
    .CLK(CLK), .RST(RST),
    .LoadValid(LoadValid), .LoadData(LoadData), .LoadLast(LoadLast),
    .LoadReady(LoadReady), .CPU_RST(CPU_RST),
    .PCF(PCF), .IM_RD(IM_RD),
    .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .DM_RD(DM_RD), .LoadCount(LoadCount), .Fault(Fault), .RunCycles(RunCycles)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    #2;
    RST = 1'b1;
    #1;
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; LoadValid = 1'b0; LoadData = '0; LoadLast = 1'b0;
    PCF = '0; MemWriteM = 1'b0; ALUOutM = '0; WriteDataM = '0;
    #12;
    check("rst_loadready", 32'(LoadReady), 32'd1);
    check("rst_cpurst",    32'(CPU_RST),   32'd1);
    check("rst_loadcount", 32'(LoadCount), 32'd0);
    check("rst_fault",     32'(Fault),     32'd0);
    check("rst_runcycles", RunCycles,      32'd0);
    check("rst_imrd",      IM_RD,          32'd0);
    tick();
    RST = 1'b0;

    // Three-word program terminated by LoadLast
    LoadValid = 1'b1; LoadData = 32'h2008_0005; tick();
    LoadData = 32'h2009_0003; tick();
    check("p3_cpurst_mid", 32'(CPU_RST), 32'd1);
    LoadData = 32'h0109_5020; LoadLast = 1'b1; tick();
    LoadValid = 1'b0; LoadLast = 1'b0;
    check("p3_loadcount", 32'(LoadCount), 32'd3);
    check("p3_cpurst",    32'(CPU_RST),   32'd0);
    check("p3_loadready", 32'(LoadReady), 32'd0);
    check("p3_runc0",     RunCycles,      32'd0);
    PCF = 32'd8;  #1 check("p3_fetch8",  IM_RD, 32'h0109_5020);
    PCF = 32'd12; #1 check("p3_fetch12", IM_RD, 32'h0000_0000);
    PCF = 32'd0;  #1 check("p3_fetch0",  IM_RD, 32'h2008_0005);
    PCF = 32'd7;  #1 check("p3_fetch7",  IM_RD, 32'h2009_0003);
    tick();
    check("p3_runc1", RunCycles, 32'd1);

    // Data write with read-during-write
    MemWriteM = 1'b1; ALUOutM = 32'h10; WriteDataM = 32'h1111_1111; tick();
    WriteDataM = 32'hDEAD_BEEF; #1;
    check("dm_old_value", DM_RD, 32'h1111_1111);
    tick();
    MemWriteM = 1'b0; #1;
    check("dm_new_value", DM_RD, 32'hDEAD_BEEF);
    check("dm_fault0", 32'(Fault), 32'd0);

    // Illegal writes: misaligned and out of range
    MemWriteM = 1'b1; ALUOutM = 32'h12; WriteDataM = 32'h5555_5555; tick();
    MemWriteM = 1'b0; #1;
    check("dm_misal_fault", 32'(Fault), 32'd1);
    check("dm_misal_rd",    DM_RD,      32'd0);
    MemWriteM = 1'b1; ALUOutM = 32'h100; tick();
    MemWriteM = 1'b0; #1;
    check("dm_oor_fault", 32'(Fault), 32'd1);
    check("dm_oor_rd",    DM_RD,      32'd0);
    tick(); tick();
    check("dm_fault_sticky", 32'(Fault), 32'd1);
    ALUOutM = 32'h10; #1;
    check("dm_intact", DM_RD, 32'hDEAD_BEEF);

    // Reset mid-load after 2 of 5 words
    pulse_reset();
    check("rst_fault_clr", 32'(Fault), 32'd0);
    tick();
    LoadValid = 1'b1; LoadData = 32'hA000_0000; tick();
    LoadData = 32'hA000_0001; tick();
    check("part_count2", 32'(LoadCount), 32'd2);
    pulse_reset();
    check("part_count0",  32'(LoadCount), 32'd0);
    check("part_ready",   32'(LoadReady), 32'd1);
    check("part_cpurst",  32'(CPU_RST),   32'd1);
    PCF = 32'd0; #1 check("part_fetch_hidden", IM_RD, 32'd0);
    // Fresh 5-word load; a data write attempted during LOAD must be ignored
    MemWriteM = 1'b1; ALUOutM = 32'h10; WriteDataM = 32'h0BAD_F00D;
    for (int i = 0; i < 5; i++) begin
      LoadData = 32'hB000_0000 + 32'(i);
      LoadLast = (i == 4);
      tick();
    end
    LoadValid = 1'b0; LoadLast = 1'b0; MemWriteM = 1'b0; #1;
    check("five_count",  32'(LoadCount), 32'd5);
    check("five_cpurst", 32'(CPU_RST),   32'd0);
    check("five_fault",  32'(Fault),     32'd0);
    check("five_dm_kept", DM_RD,         32'hDEAD_BEEF);
    PCF = 32'd16; #1 check("five_fetch16", IM_RD, 32'hB000_0004);
    PCF = 32'd20; #1 check("five_fetch20", IM_RD, 32'd0);

    // Stall in LOAD for 20 cycles
    pulse_reset();
    for (int i = 0; i < 20; i++) tick();
    check("stall_ready",  32'(LoadReady), 32'd1);
    check("stall_cpurst", 32'(CPU_RST),   32'd1);
    check("stall_count",  32'(LoadCount), 32'd0);
    check("stall_runc",   RunCycles,      32'd0);

    // Full-depth load without LoadLast auto-terminates
    LoadValid = 1'b1;
    for (int i = 0; i < 63; i++) begin
      LoadData = 32'h1000_0000 + 32'(i);
      tick();
    end
    check("full_ready63", 32'(LoadReady), 32'd1);
    LoadData = 32'h1000_003F; tick();
    check("full_ready64", 32'(LoadReady), 32'd0);
    check("full_count",   32'(LoadCount), 32'd64);
    LoadData = 32'hFFFF_FFFF; tick();
    LoadValid = 1'b0; #1;
    check("full_65th_ignored", 32'(LoadCount), 32'd64);
    PCF = 32'd252; #1 check("full_fetch_last", IM_RD, 32'h1000_003F);
    PCF = 32'd256; #1 check("full_fetch_oor",  IM_RD, 32'd0);
    PCF = 32'd128; #1 check("full_fetch_mid",  IM_RD, 32'h1000_0020);
    check("full_runc", RunCycles, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
